irq_controller: RTL and testbench

- Round-robin interrupt arbiter and trap sequencer for the single-issue RISC-V core.
- Collects up to N_IRQ level-sensitive peripheral requests and masks them with the mie CSR value.
- Picks one winner and drives the decoder's INT_i line, which redirects the PC to mtvec and suppresses the GPR write and memory request for that instruction.
- Supplies mcause to the CSR file, waits for mret (the decoder's INT_RST_o), then acknowledges the serviced peripheral.

---
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_controller.sv | 107 ++++++++++
 tb/tb_irq_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Interrupt controller bus: peripheral requests, CSR mask, decoder handshake.
// master drives requests/mask/enpc/mret; slave (controller) drives trap, cause, ack, busy.
interface irq_controller_if #(
    parameter int N_IRQ = 16
);
    logic [N_IRQ-1:0] irq_req_i;
    logic [N_IRQ-1:0] mie_i;
    logic             enpc_i;
    logic             int_rst_i;
    logic             int_o;
    logic [31:0]      mcause_o;
    logic [N_IRQ-1:0] irq_ack_o;
    logic             busy_o;

    modport master (
        output irq_req_i, mie_i, enpc_i, int_rst_i,
        input  int_o, mcause_o, irq_ack_o, busy_o
    );

    modport slave (
        input  irq_req_i, mie_i, enpc_i, int_rst_i,
        output int_o, mcause_o, irq_ack_o, busy_o
    );
endinterface

// File: rtl/irq_controller.sv
// Round-robin interrupt arbiter and trap sequencer (IDLE->REQ->SERVICE->ACK).
// Ports: clk_i, rst_i (sync, active-high), bus (irq_controller_if.slave).
module irq_controller #(
    parameter int N_IRQ = 16
) (
    input logic clk_i,
    input logic rst_i,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE,
        ACK
    } state_t;

    state_t           r_state;
    logic [4:0]       r_id;
    logic [4:0]       r_ptr;
    logic [31:0]      r_mcause;
    logic             r_int;
    logic             r_busy;
    logic [N_IRQ-1:0] r_ack;

    logic [N_IRQ-1:0] w_pend;
    logic [31:0]      w_pend32;
    logic [4:0]       w_win;
    logic [4:0]       w_ptr_nxt;
    logic [31:0]      w_ack32;

    assign w_pend   = bus.irq_req_i & bus.mie_i;
    assign w_pend32 = 32'(w_pend);
    assign w_ack32  = 32'd1 << r_id;

    // Wrap at N_IRQ rather than at 32.
    assign w_ptr_nxt = (r_id == 5'(N_IRQ - 1)) ? 5'd0 : r_id + 5'd1;

    // Scan from the far end back toward ptr so the last hit is the
    // first set bit in round-robin order starting at ptr.
    always_comb begin
        w_win = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= N_IRQ) j = j - N_IRQ;
            if (w_pend32[j[4:0]]) w_win = j[4:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_id     <= 5'd0;
            r_ptr    <= 5'd0;
            r_mcause <= 32'd0;
            r_int    <= 1'b0;
            r_busy   <= 1'b0;
            r_ack    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|w_pend) begin
                        r_id     <= w_win;
                        r_mcause <= {1'b1, 26'b0, w_win};
                        r_state  <= REQ;
                        r_int    <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                REQ: begin
                    // Pipeline advance wins over a withdrawn request.
                    if (bus.enpc_i) begin
                        r_state <= SERVICE;
                        r_int   <= 1'b0;
                    end else if (!w_pend32[r_id]) begin
                        r_state <= IDLE;
                        r_int   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.int_rst_i) begin
                        r_state <= ACK;
                        r_ack   <= w_ack32[N_IRQ-1:0];
                    end
                end
                ACK: begin
                    r_ack   <= '0;
                    r_ptr   <= w_ptr_nxt;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_int   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ack   <= '0;
                end
            endcase
        end
    end

    assign bus.int_o     = r_int;
    assign bus.mcause_o  = r_mcause;
    assign bus.irq_ack_o = r_ack;
    assign bus.busy_o    = r_busy;
endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller: vector table plus a handshake sequence.
// Inputs change after #1 past posedge; outputs checked #1 after the next posedge.
module tb_irq_controller;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_controller_if #(.N_IRQ(N)) bus ();

    irq_controller #(.N_IRQ(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] mie;
        logic        enpc;
        logic        irst;
        logic        eint;
        logic [31:0] emc;
        logic [15:0] eack;
        logic        ebusy;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic v(input logic r, input logic [15:0] rq,
                     input logic [15:0] mk, input logic en,
                     input logic ir, input logic ei,
                     input logic [31:0] mc, input logic [15:0] ak,
                     input logic bz);
        vec_t t;
        t = '{r, rq, mk, en, ir, ei, mc, ak, bz};
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.irq_req_i = '0;
        bus.mie_i     = '1;
        bus.enpc_i    = 1'b1;
        bus.int_rst_i = 1'b0;

        // reset, single line 5
        v(1,'h0000,'hFFFF,1,0, 0,'h0,'h0,0);
        v(0,'h0020,'hFFFF,1,0, 1,'h80000005,'h0,1);
        v(0,'h0020,'hFFFF,1,0, 0,'h80000005,'h0,1);
        v(0,'h0020,'hFFFF,1,0, 0,'h80000005,'h0,1);
        v(0,'h0020,'hFFFF,1,1, 0,'h80000005,'h0020,1);
        v(0,'h0000,'hFFFF,1,0, 0,'h80000005,'h0,0);
        // round-robin 0,15,0,15
        v(1,'h0000,'hFFFF,1,0, 0,'h0,'h0,0);
        v(0,'h8001,'hFFFF,1,0, 1,'h80000000,'h0,1);
        v(0,'h8001,'hFFFF,1,0, 0,'h80000000,'h0,1);
        v(0,'h8001,'hFFFF,1,1, 0,'h80000000,'h0001,1);
        v(0,'h8001,'hFFFF,1,0, 0,'h80000000,'h0,0);
        v(0,'h8001,'hFFFF,1,0, 1,'h8000000F,'h0,1);
        v(0,'h8001,'hFFFF,1,0, 0,'h8000000F,'h0,1);
        v(0,'h8001,'hFFFF,1,1, 0,'h8000000F,'h8000,1);
        v(0,'h8001,'hFFFF,1,0, 0,'h8000000F,'h0,0);
        v(0,'h8001,'hFFFF,1,0, 1,'h80000000,'h0,1);
        v(0,'h8001,'hFFFF,1,0, 0,'h80000000,'h0,1);
        v(0,'h8001,'hFFFF,1,1, 0,'h80000000,'h0001,1);
        v(0,'h8001,'hFFFF,1,0, 0,'h80000000,'h0,0);
        v(0,'h8001,'hFFFF,1,0, 1,'h8000000F,'h0,1);
        v(0,'h8001,'hFFFF,1,0, 0,'h8000000F,'h0,1);
        v(0,'h8001,'hFFFF,1,1, 0,'h8000000F,'h8000,1);
        v(0,'h0000,'hFFFF,1,0, 0,'h8000000F,'h0,0);
        // mask, then stall cancel
        v(0,'h0004,'h0000,1,0, 0,'h8000000F,'h0,0);
        v(0,'h0004,'h0000,1,0, 0,'h8000000F,'h0,0);
        v(0,'h0004,'h0004,0,0, 1,'h80000002,'h0,1);
        v(0,'h0004,'h0004,0,0, 1,'h80000002,'h0,1);
        v(0,'h0004,'h0000,0,0, 0,'h80000002,'h0,0);
        v(0,'h0004,'h0000,0,0, 0,'h80000002,'h0,0);
        // ptr still 0: lines 2,4 -> 2 wins
        v(0,'h0014,'hFFFF,1,0, 1,'h80000002,'h0,1);
        v(0,'h0014,'hFFFF,1,0, 0,'h80000002,'h0,1);
        v(0,'h0014,'hFFFF,1,1, 0,'h80000002,'h0004,1);
        v(0,'h0000,'hFFFF,1,0, 0,'h80000002,'h0,0);
        // stall 3 cycles, line 9 waits for ack
        v(0,'h0002,'hFFFF,0,0, 1,'h80000001,'h0,1);
        v(0,'h0002,'hFFFF,0,0, 1,'h80000001,'h0,1);
        v(0,'h0002,'hFFFF,0,0, 1,'h80000001,'h0,1);
        v(0,'h0002,'hFFFF,0,0, 1,'h80000001,'h0,1);
        v(0,'h0002,'hFFFF,1,0, 0,'h80000001,'h0,1);
        v(0,'h0202,'hFFFF,1,0, 0,'h80000001,'h0,1);
        v(0,'h0202,'hFFFF,1,0, 0,'h80000001,'h0,1);
        v(0,'h0202,'hFFFF,1,1, 0,'h80000001,'h0002,1);
        v(0,'h0200,'hFFFF,1,0, 0,'h80000001,'h0,0);
        v(0,'h0200,'hFFFF,1,0, 1,'h80000009,'h0,1);
        v(0,'h0200,'hFFFF,1,0, 0,'h80000009,'h0,1);
        v(0,'h0200,'hFFFF,1,1, 0,'h80000009,'h0200,1);
        v(0,'h0000,'hFFFF,1,0, 0,'h80000009,'h0,0);
        // spurious mret, enpc with withdrawn pend
        v(0,'h0000,'hFFFF,1,1, 0,'h80000009,'h0,0);
        v(0,'h0008,'hFFFF,0,0, 1,'h80000003,'h0,1);
        v(0,'h0000,'hFFFF,1,0, 0,'h80000003,'h0,1);
        v(0,'h0000,'hFFFF,1,1, 0,'h80000003,'h0008,1);
        v(0,'h0000,'hFFFF,1,0, 0,'h80000003,'h0,0);
        v(0,'h0010,'hFFFF,0,0, 1,'h80000004,'h0,1);
        v(0,'h0010,'hFFFF,0,1, 1,'h80000004,'h0,1);
        v(0,'h0010,'hFFFF,1,0, 0,'h80000004,'h0,1);
        // reset mid-SERVICE
        v(1,'h0010,'hFFFF,1,0, 0,'h0,'h0,0);
        v(0,'h0000,'hFFFF,1,1, 0,'h0,'h0,0);
        v(0,'h0000,'hFFFF,1,0, 0,'h0,'h0,0);
        v(0,'h0014,'hFFFF,1,0, 1,'h80000002,'h0,1);
        v(0,'h0014,'hFFFF,1,0, 0,'h80000002,'h0,1);
        v(0,'h0014,'hFFFF,1,1, 0,'h80000002,'h0004,1);
        v(0,'h0000,'hFFFF,1,0, 0,'h80000002,'h0,0);

        foreach (vq[k]) begin
            rst           = vq[k].rst;
            bus.irq_req_i = vq[k].req;
            bus.mie_i     = vq[k].mie;
            bus.enpc_i    = vq[k].enpc;
            bus.int_rst_i = vq[k].irst;
            step();
            n_vec++;
            if (bus.int_o !== vq[k].eint ||
                bus.mcause_o !== vq[k].emc ||
                bus.irq_ack_o !== vq[k].eack ||
                bus.busy_o !== vq[k].ebusy) begin
                n_bad++;
                $display("FAIL vec%0d: got int=%b mc=%h ack=%h busy=%b expected int=%b mc=%h ack=%h busy=%b",
                         k, bus.int_o, bus.mcause_o, bus.irq_ack_o,
                         bus.busy_o, vq[k].eint, vq[k].emc,
                         vq[k].eack, vq[k].ebusy);
            end
        end

        // handshake on line 7 with bounded waits; ptr is 3 here
        begin
            bit seen;
            seen = 1'b0;
            rst           = 1'b0;
            bus.int_rst_i = 1'b0;
            bus.enpc_i    = 1'b1;
            bus.irq_req_i = 16'h0080;
            for (int c = 0; c < 8 && !seen; c++) begin
                step();
                if (bus.int_o === 1'b1) seen = 1'b1;
            end
            chk("seq_int_seen", 32'(seen), 32'd1);
            chk("seq_mcause", bus.mcause_o, 32'h8000_0007);
            step();
            chk("seq_service", {30'd0, bus.busy_o, bus.int_o},
                32'd2);
            bus.int_rst_i = 1'b1;
            step();
            bus.int_rst_i = 1'b0;
            bus.irq_req_i = 16'h0000;
            chk("seq_ack", 32'(bus.irq_ack_o), 32'h0080);
            step();
            chk("seq_idle", {15'd0, bus.busy_o, bus.irq_ack_o},
                32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
